// File: rtl/gpr_file_pkg.sv
// gpr_file_pkg: shared types and helpers for the general-purpose register file.
// Contents:
//   sb_op_e - action applied to one pending-write counter in a cycle
//   sb_op() - resolves the issue/release hits on one entry into that action
`ifndef GPR_DEFINES_SV
`include "core_defines.sv"
`endif

package gpr_file_pkg;

    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_INC  = 2'd1,
        SB_DEC  = 2'd2
    } sb_op_e;

    // An issue and a release to the same entry in one cycle cancel out.
    function automatic sb_op_e sb_op(input logic issue_hit, input logic rel_hit);
        if (issue_hit && !rel_hit) begin
            return SB_INC;
        end
        if (rel_hit && !issue_hit) begin
            return SB_DEC;
        end
        return SB_HOLD;
    endfunction

endpackage

// File: rtl/core_defines.sv
// Shared core defines.
// Provides the architectural register-file geometry and the default width
// of the per-register pending-write counters used by the GPR scoreboard.
// Guarded so it can be included from several files or compiled on its own.
`ifndef GPR_DEFINES_SV
`define GPR_DEFINES_SV

`define GPR_WIDTH      32
`define GPR_ADDR_SPACE 5
`define GPR_SB_CNT_W   2

`endif

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register pending-write counters.
// Each register 1..2^ADDR_W-1 owns a saturating CNT_W-bit counter of
// in-flight producers. Register 0 has no counter and is never busy.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   issue, issue_addr      - claim one pending write on issue_addr
//   rel, rel_addr          - release one claim on rel_addr
//   rs1_addr, rs2_addr     - source addresses being checked
//   rs1_busy, rs2_busy     - source still has an unretired producer
//   err                    - sticky counter overflow/underflow flag
`ifndef GPR_DEFINES_SV
`include "core_defines.sv"
`endif

module gpr_scoreboard
    import gpr_file_pkg::*;
#(
    parameter int ADDR_W = `GPR_ADDR_SPACE,
    parameter int CNT_W  = `GPR_SB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              rel,
    input  logic [ADDR_W-1:0] rel_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              err
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_vec [NREG];
    logic [NREG-1:0]  fault_vec;
    logic             err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt_vec[gi]   = '0;
                assign fault_vec[gi] = 1'b0;
            end else begin : g_entry
                logic [CNT_W-1:0] cnt_reg;
                logic             issue_hit;
                logic             rel_hit;
                sb_op_e           op;

                assign issue_hit = issue && (issue_addr == ADDR_W'(gi));
                assign rel_hit   = rel && (rel_addr == ADDR_W'(gi));
                assign op        = sb_op(issue_hit, rel_hit);

                // Counters saturate rather than wrap; the fault is flagged instead.
                assign fault_vec[gi] = ((op == SB_INC) && (cnt_reg == CNT_MAX)) ||
                                       ((op == SB_DEC) && (cnt_reg == '0));

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt_reg <= '0;
                    end else begin
                        case (op)
                            SB_INC: if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
                            SB_DEC: if (cnt_reg != '0)      cnt_reg <= cnt_reg - 1'b1;
                            default: ;
                        endcase
                    end
                end

                assign cnt_vec[gi] = cnt_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (|fault_vec) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

    // A release landing this cycle retires one claim early: the WB bypass in
    // the register file supplies that value, so only the remaining claims count.
    // A same-cycle issue is deliberately not visible until the next cycle.
    logic rs1_rel;
    logic rs2_rel;

    assign rs1_rel  = rel && (rel_addr == rs1_addr);
    assign rs2_rel  = rel && (rel_addr == rs2_addr);

    assign rs1_busy = (rs1_addr != '0) &&
                      (rs1_rel ? (cnt_vec[rs1_addr] > CNT_W'(1)) : (cnt_vec[rs1_addr] != '0));
    assign rs2_busy = (rs2_addr != '0) &&
                      (rs2_rel ? (cnt_vec[rs2_addr] > CNT_W'(1)) : (cnt_vec[rs2_addr] != '0));

endmodule

// File: rtl/gpr_file.sv
// gpr_file: general-purpose register file with write-through bypass and a
// pending-write scoreboard.
// Register 0 always reads zero and ignores writes. Reads are combinational;
// a WB write to the register being read is forwarded in the same cycle.
// Ports:
//   clk_i, rst_i                    - clock, asynchronous active-high reset
//   rs1_addr_i/rs2_addr_i           - ID read addresses
//   rs1_val_o/rs2_val_o             - read data (bypassed)
//   rs1_busy_o/rs2_busy_o           - source has an unretired producer
//   issue_i, issue_rd_addr_i        - claim a destination at issue
//   rd_val_i, rd_addr_i, rd_we_i    - WB write port
//   rd_rel_i                        - release one claim on rd_addr_i
//   sb_err_o                        - sticky scoreboard overflow/underflow
`ifndef GPR_DEFINES_SV
`include "core_defines.sv"
`endif

module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_W = `GPR_WIDTH,
    parameter int ADDR_W = `GPR_ADDR_SPACE,
    parameter int CNT_W  = `GPR_SB_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_val_o,
    output logic [DATA_W-1:0] rs2_val_o,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_rd_addr_i,
    input  logic [DATA_W-1:0] rd_val_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_we_i,
    input  logic              rd_rel_i,
    output logic              sb_err_o
);

    localparam int NREG = 1 << ADDR_W;

    // Entry 0 exists only to keep indexing simple; it is never written and
    // the read path masks it to zero regardless.
    logic [DATA_W-1:0] regs_reg [NREG];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (rd_we_i && (rd_addr_i != '0)) begin
            regs_reg[rd_addr_i] <= rd_val_i;
        end
    end

    logic [ADDR_W-1:0] rs_addr [2];
    logic [DATA_W-1:0] rs_val  [2];

    assign rs_addr[0] = rs1_addr_i;
    assign rs_addr[1] = rs2_addr_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rs_val[gi] = '0;
                if (rs_addr[gi] != '0) begin
                    if (rd_we_i && (rd_addr_i == rs_addr[gi])) begin
                        rs_val[gi] = rd_val_i;
                    end else begin
                        rs_val[gi] = regs_reg[rs_addr[gi]];
                    end
                end
            end
        end
    endgenerate

    assign rs1_val_o = rs_val[0];
    assign rs2_val_o = rs_val[1];

    gpr_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk        (clk_i),
        .rst        (rst_i),
        .issue      (issue_i),
        .issue_addr (issue_rd_addr_i),
        .rel        (rd_rel_i),
        .rel_addr   (rd_addr_i),
        .rs1_addr   (rs1_addr_i),
        .rs2_addr   (rs2_addr_i),
        .rs1_busy   (rs1_busy_o),
        .rs2_busy   (rs2_busy_o),
        .err        (sb_err_o)
    );

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL have parameter DATA_W, default `GPR_WIDTH (32), register width.
REQ-002 SHALL have parameter ADDR_W, default `GPR_ADDR_SPACE (5), register address width.
REQ-003 SHALL have parameter CNT_W, default 2, per-register pending-write counter width.
REQ-004 SHALL have port clk_i  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports rs1_addr_i, rs2_addr_i  in  ADDR_W  ID read addresses.
REQ-007 SHALL have ports rs1_val_o, rs2_val_o  out  DATA_W  read data, combinational.
REQ-008 SHALL have ports rs1_busy_o, rs2_busy_o  out  1  source has an unretired producer.
REQ-009 SHALL have port issue_i  in  1  ID issues an instruction that claims issue_rd_addr_i.
REQ-010 SHALL have port issue_rd_addr_i  in  ADDR_W  destination claimed at issue.
REQ-011 SHALL have ports rd_val_i, rd_addr_i, rd_we_i  in  DATA_W/ADDR_W/1  WB write port from the MEM/WB stage register.
REQ-012 SHALL have port rd_rel_i  in  1  release of one claim on rd_addr_i, asserted for every claimed instruction reaching WB, killed or not.
REQ-013 SHALL have port sb_err_o  out  1  sticky scoreboard overflow/underflow flag.

Function
REQ-014 SHALL hold 2^ADDR_W registers; entry 0 SHALL read 0 and never be written.
REQ-015 SHALL write rd_val_i into entry rd_addr_i at the clock edge when rd_we_i=1 and rd_addr_i!=0.
REQ-016 SHALL read combinationally: rsN_val_o = rd_val_i when rd_we_i=1, rd_addr_i=rsN_addr_i!=0 (write-through bypass); otherwise the stored entry; otherwise 0 for address 0.
REQ-017 SHALL keep one CNT_W-bit counter per entry 1..2^ADDR_W-1; entry 0 has no counter.
REQ-018 SHALL increment cnt[a] when issue_i=1, a=issue_rd_addr_i!=0, and no release to a occurs in the same cycle.
REQ-019 SHALL decrement cnt[a] when rd_rel_i=1, a=rd_addr_i!=0, and no issue to a occurs in the same cycle; issue and release to the same a in one cycle SHALL leave cnt[a] unchanged.
REQ-020 SHALL, on increment at max (2^CNT_W-1), hold the counter and set sb_err_o.
REQ-021 SHALL, on decrement at 0, hold 0 and set sb_err_o.
REQ-022 SHALL drive rsN_busy_o = 1 iff rsN_addr_i!=0 and (cnt[rsN] - (rd_rel_i && rd_addr_i==rsN ? 1 : 0)) > 0; a same-cycle release of the last claim SHALL therefore clear busy, since the bypass supplies the value.
REQ-023 SHALL NOT let a same-cycle issue affect rsN_busy_o; issue is visible from the next cycle.
REQ-024 SHALL keep sb_err_o at 1 until reset once set.
REQ-025 SHALL handle issue_i and rd_rel_i to different addresses in the same cycle independently.

Reset
REQ-026 SHALL, while rst_i=1, asynchronously clear all registers, all counters and sb_err_o to 0.
REQ-027 SHALL ignore rd_we_i, issue_i and rd_rel_i while rst_i=1; reset mid-operation discards all pending claims.
REQ-028 SHALL resume normal updates at the first rising edge after rst_i deasserts.

Structure
REQ-029 SHALL take GPR_WIDTH and GPR_ADDR_SPACE from the shared core defines header; CNT_W default SHALL be defined there as GPR_SB_CNT_W.
REQ-030 SHALL place the pending-write counters in one sub-module, gpr_scoreboard, instantiated once; storage and bypass remain in gpr_file.

Verification
REQ-031 SHALL cover: write x5=0xDEADBEEF, next cycle read rs1=5 -> rs1_val_o=0xDEADBEEF; write x0=0x1234 -> read x0=0.
REQ-032 SHALL cover: same-cycle rd_we_i=1 to x7=0xA5A5A5A5 with rs2_addr_i=7 -> rs2_val_o=0xA5A5A5A5 in that cycle.
REQ-033 SHALL cover: issue x3, next cycle rs1=3 -> busy=1; cycle of rd_rel_i to x3 -> busy=0, val=rd_val_i.
REQ-034 SHALL cover: issue x4 twice, release once -> busy stays 1; release again -> busy 0, sb_err_o=0.
REQ-035 SHALL cover: release x9 with cnt 0 -> sb_err_o=1 sticky; four issues to x9 without release -> cnt holds 3, sb_err_o=1.
REQ-036 SHALL cover: assert rst_i asynchronously mid-edge with cnt[2]=2, x2=0x55 -> immediately x2 reads 0, busy 0, sb_err_o 0.
